mips_mc_control: RTL and testbench

// - Multi-cycle MIPS control FSM; produces the 4-bit ALU op code, ALU operand selects and datapath enables.
// - Decodes the latched instruction (opcode/funct); consumes the ALU zero flag for branches.
// - Sits between instruction/data memory handshake and the datapath.
// - Counts retired instructions.

---
 rtl/mips_mc_control.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle MIPS control FSM.
// Decodes the latched instruction, sequences fetch/decode/execute/memory/writeback,
// and drives ALU op/operand selects plus datapath enables. Counts retired instructions.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   instr               instruction register contents (valid from DECODE on)
//   zero                ALU zero flag, used in BRANCH
//   mem_ready           memory access completes this cycle
//   alu_op              4-bit ALU operation code
//   alu_src_a/_b        ALU operand selects
//   ir_we, pc_we        IR / PC load enables; pc_src selects the PC source
//   mem_re, mem_we      memory read/write requests; mem_iord picks PC (0) or ALUOut (1)
//   reg_we, reg_dst     register file write and destination (0 rt, 1 rd)
//   mem_to_reg          write-back source (0 ALUOut, 1 memory data)
//   illegal             one-cycle pulse on an undecodable instruction
//   retired             retired-instruction count (wraps)
module mips_mc_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [3:0]       alu_op,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             mem_re,
  output logic             mem_we,
  output logic             mem_iord,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_MUL = 4'b1001;
  localparam logic [3:0] ALU_NOR = 4'b1111;

  // Operand select codes
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_REG   = 2'b01;
  localparam logic [1:0] SRC_A_SHAMT = 2'b10;
  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_IMM4  = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_R,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_ILLEGAL
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       retire_c;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [3:0] r_alu_op;
  logic       r_ok;
  logic       r_shift;
  logic [3:0] i_alu_op;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  // Register/immediate fields are consumed by the datapath, not the controller.
  assign unused_instr = ^instr[25:6];

  // R-type funct decode: ALU op, legality, shift-amount operand
  always_comb begin
    r_alu_op = ALU_ADD;
    r_ok     = 1'b1;
    r_shift  = 1'b0;
    case (funct)
      FN_ADD:  r_alu_op = ALU_ADD;
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_OR:   r_alu_op = ALU_OR;
      FN_AND:  r_alu_op = ALU_AND;
      FN_XOR:  r_alu_op = ALU_XOR;
      FN_NOR:  r_alu_op = ALU_NOR;
      FN_SLT:  r_alu_op = ALU_SLT;
      FN_MUL:  r_alu_op = ALU_MUL;
      FN_SRL:  begin r_alu_op = ALU_SRL; r_shift = 1'b1; end
      FN_SLL:  begin r_alu_op = ALU_SLL; r_shift = 1'b1; end
      default: r_ok = 1'b0;
    endcase
  end

  // I-type opcode to ALU op
  always_comb begin
    i_alu_op = ALU_ADD;
    case (opcode)
      OP_ANDI: i_alu_op = ALU_AND;
      OP_ORI:  i_alu_op = ALU_OR;
      OP_XORI: i_alu_op = ALU_XOR;
      OP_SLTI: i_alu_op = ALU_SLT;
      default: i_alu_op = ALU_ADD;
    endcase
  end

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (retire_c) retired <= retired + CNT_W'(1);
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_nxt  = state;
    retire_c   = 1'b0;
    alu_op     = ALU_ADD;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_REG;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_iord   = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_re    = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculative branch target PC+(imm<<2), captured in ALUOut
        alu_src_b = SRC_B_IMM4;
        case (opcode)
          OP_RTYPE:                                      state_nxt = S_EXEC_R;
          OP_LW, OP_SW:                                  state_nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                                state_nxt = S_BRANCH;
          OP_J:                                          state_nxt = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:    state_nxt = S_EXEC_I;
          default:                                       state_nxt = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        alu_op    = r_ok ? r_alu_op : ALU_ADD;
        alu_src_a = r_shift ? SRC_A_SHAMT : SRC_A_REG;
        alu_src_b = SRC_B_REG;
        state_nxt = r_ok ? S_WB_R : S_ILLEGAL;
      end
      S_EXEC_I: begin
        alu_op    = i_alu_op;
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        state_nxt = S_WB_I;
      end
      S_WB_R: begin
        reg_we    = 1'b1;
        reg_dst   = 1'b1;
        retire_c  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_WB_I: begin
        reg_we    = 1'b1;
        retire_c  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_re   = 1'b1;
        mem_iord = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        retire_c   = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_we   = 1'b1;
        mem_iord = 1'b1;
        if (mem_ready) begin
          retire_c  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_op    = ALU_SUB;
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_REG;
        pc_src    = PC_ALUOUT;
        pc_we     = (opcode == OP_BNE) ? ~zero : zero;
        retire_c  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pc_we     = 1'b1;
        pc_src    = PC_JUMP;
        retire_c  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal   = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase

    // While reset is asserted every request and enable is forced low,
    // which also drops any in-flight bus request immediately.
    if (!rst_n) begin
      retire_c   = 1'b0;
      alu_op     = ALU_ADD;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_REG;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PC_ALU;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      mem_iord   = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: per-instruction cycle model built from
// instruction class, with random instructions, stalls and zero flag.
module tb_mips_mc_control;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      instr;
  logic             zero;
  logic             mem_ready;
  logic [3:0]       alu_op;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             mem_re;
  logic             mem_we;
  logic             mem_iord;
  logic             reg_we;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  typedef struct packed {
    logic       illegal;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_we;
    logic       mem_iord;
    logic       mem_we;
    logic       mem_re;
    logic [1:0] pc_src;
    logic       pc_we;
    logic       ir_we;
    logic [1:0] src_b;
    logic [1:0] src_a;
    logic [3:0] alu_op;
  } exp_t;

  exp_t obs;
  assign obs = {illegal, mem_to_reg, reg_dst, reg_we, mem_iord, mem_we, mem_re,
                pc_src, pc_we, ir_we, alu_src_b, alu_src_a, alu_op};

  mips_mc_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .mem_re(mem_re), .mem_we(mem_we), .mem_iord(mem_iord),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] ret_model;

  task automatic check_out(input string tag, input exp_t e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s outputs observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check_ret(input string tag, input logic [CNT_W-1:0] e);
    checks++;
    assert (retired === e) else begin
      errors++;
      $error("FAIL %s retired observed=%0d expected=%0d", tag, retired, e);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Entered 1 time unit after a rising edge; leaves 1 unit after the next one.
  task automatic step(input string tag, input logic mr, input logic z,
                      input exp_t e, input logic retire);
    mem_ready = mr;
    zero      = z;
    #2;
    check_out(tag, e);
    check_ret(tag, ret_model);
    @(posedge clk);
    #1;
    if (retire) ret_model = ret_model + CNT_W'(1);
  endtask

  // R-type table: {legal, alu_op}
  function automatic logic [4:0] r_info(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, 4'b0000};
      6'b100010: return {1'b1, 4'b0001};
      6'b100101: return {1'b1, 4'b0010};
      6'b100100: return {1'b1, 4'b0011};
      6'b100110: return {1'b1, 4'b0100};
      6'b100111: return {1'b1, 4'b1111};
      6'b101010: return {1'b1, 4'b1000};
      6'b011000: return {1'b1, 4'b1001};
      6'b000010: return {1'b1, 4'b0101};
      6'b000000: return {1'b1, 4'b0110};
      default:   return {1'b0, 4'b0000};
    endcase
  endfunction

  // Runs one whole instruction, checking every cycle against its class sequence.
  task automatic run_instr(input string tag, input logic [31:0] ins,
                           input int f_stall, input int m_stall, input logic z);
    exp_t e;
    logic [5:0] op;
    logic [4:0] ri;
    op    = ins[31:26];
    instr = ins;
    e = '0; e.mem_re = 1'b1; e.src_b = 2'b01;
    for (int i = 0; i < f_stall; i++) step({tag, "/F_wait"}, 1'b0, rbit(), e, 1'b0);
    e.ir_we = 1'b1; e.pc_we = 1'b1;
    step({tag, "/F"}, 1'b1, rbit(), e, 1'b0);
    e = '0; e.src_b = 2'b11;
    step({tag, "/D"}, rbit(), rbit(), e, 1'b0);
    case (op)
      6'b000000: begin
        ri = r_info(ins[5:0]);
        e = '0;
        e.alu_op = ri[3:0];
        e.src_a  = (ins[5:0] == 6'b000000 || ins[5:0] == 6'b000010) ? 2'b10 : 2'b01;
        step({tag, "/EX"}, rbit(), rbit(), e, 1'b0);
        e = '0;
        if (ri[4]) begin
          e.reg_we = 1'b1; e.reg_dst = 1'b1;
          step({tag, "/WB"}, rbit(), rbit(), e, 1'b1);
        end else begin
          e.illegal = 1'b1;
          step({tag, "/ILL"}, rbit(), rbit(), e, 1'b0);
        end
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: begin
        e = '0; e.src_a = 2'b01; e.src_b = 2'b10;
        e.alu_op = (op == 6'b001100) ? 4'b0011 :
                   (op == 6'b001101) ? 4'b0010 :
                   (op == 6'b001110) ? 4'b0100 :
                   (op == 6'b001010) ? 4'b1000 : 4'b0000;
        step({tag, "/EXI"}, rbit(), rbit(), e, 1'b0);
        e = '0; e.reg_we = 1'b1;
        step({tag, "/WBI"}, rbit(), rbit(), e, 1'b1);
      end
      6'b100011, 6'b101011: begin
        e = '0; e.src_a = 2'b01; e.src_b = 2'b10;
        step({tag, "/MA"}, rbit(), rbit(), e, 1'b0);
        e = '0; e.mem_iord = 1'b1;
        if (op == 6'b100011) begin
          e.mem_re = 1'b1;
          for (int i = 0; i < m_stall; i++) step({tag, "/MR_wait"}, 1'b0, rbit(), e, 1'b0);
          step({tag, "/MR"}, 1'b1, rbit(), e, 1'b0);
          e = '0; e.reg_we = 1'b1; e.mem_to_reg = 1'b1;
          step({tag, "/MWB"}, rbit(), rbit(), e, 1'b1);
        end else begin
          e.mem_we = 1'b1;
          for (int i = 0; i < m_stall; i++) step({tag, "/MW_wait"}, 1'b0, rbit(), e, 1'b0);
          step({tag, "/MW"}, 1'b1, rbit(), e, 1'b1);
        end
      end
      6'b000100, 6'b000101: begin
        e = '0; e.alu_op = 4'b0001; e.src_a = 2'b01; e.pc_src = 2'b01;
        e.pc_we = (op == 6'b000100) ? z : ~z;
        step({tag, "/BR"}, rbit(), z, e, 1'b1);
      end
      6'b000010: begin
        e = '0; e.pc_we = 1'b1; e.pc_src = 2'b10;
        step({tag, "/J"}, rbit(), rbit(), e, 1'b1);
      end
      default: begin
        e = '0; e.illegal = 1'b1;
        step({tag, "/ILL"}, rbit(), rbit(), e, 1'b0);
      end
    endcase
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] f);
    logic [31:0] v;
    v = $urandom;
    v[31:26] = 6'b000000;
    v[5:0]   = f;
    return v;
  endfunction

  function automatic logic [31:0] mk_op(input logic [5:0] o);
    logic [31:0] v;
    v = $urandom;
    v[31:26] = o;
    return v;
  endfunction

  initial begin
    logic [5:0] fl [10];
    logic [5:0] il [5];
    logic [31:0] ins;
    exp_t e;
    fl = '{6'b100000, 6'b100010, 6'b100101, 6'b100100, 6'b100110,
           6'b100111, 6'b101010, 6'b011000, 6'b000010, 6'b000000};
    il = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};

    rst_n = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    // Reset asserted: everything low regardless of inputs
    mem_ready = 1'b1; zero = 1'b1; #2;
    check_out("reset_outputs", exp_t'('0));
    check_ret("reset_retired", CNT_W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    ret_model = '0;

    // Directed cases
    run_instr("add",  mk_r(6'b100000), 0, 0, 1'b0);
    run_instr("sll",  {6'b0, 5'd0, 5'd3, 5'd4, 5'd5, 6'b000000}, 0, 0, 1'b0);
    run_instr("nor",  mk_r(6'b100111), 0, 0, 1'b0);
    run_instr("mul",  mk_r(6'b011000), 0, 0, 1'b0);
    run_instr("slt",  mk_r(6'b101010), 0, 0, 1'b0);
    run_instr("srl",  mk_r(6'b000010), 0, 0, 1'b0);
    run_instr("lw_stall3", mk_op(6'b100011), 0, 3, 1'b0);
    run_instr("sw_stall2", mk_op(6'b101011), 1, 2, 1'b0);
    run_instr("beq_z1", mk_op(6'b000100), 0, 0, 1'b1);
    run_instr("bne_z1", mk_op(6'b000101), 0, 0, 1'b1);
    run_instr("illegal_op", mk_op(6'b111111), 0, 0, 1'b0);
    run_instr("addi", mk_op(6'b001000), 2, 0, 1'b0);

    // Reset in the middle of a stalled store
    instr = mk_op(6'b101011);
    e = '0; e.mem_re = 1'b1; e.src_b = 2'b01; e.ir_we = 1'b1; e.pc_we = 1'b1;
    step("rst_sw/F", 1'b1, 1'b0, e, 1'b0);
    e = '0; e.src_b = 2'b11;
    step("rst_sw/D", 1'b0, 1'b0, e, 1'b0);
    e = '0; e.src_a = 2'b01; e.src_b = 2'b10;
    step("rst_sw/MA", 1'b0, 1'b0, e, 1'b0);
    e = '0; e.mem_we = 1'b1; e.mem_iord = 1'b1;
    step("rst_sw/MW_wait", 1'b0, 1'b0, e, 1'b0);
    rst_n = 1'b0; mem_ready = 1'b0; #2;
    check_out("rst_sw/during_reset", exp_t'('0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    ret_model = '0;
    e = '0; e.mem_re = 1'b1; e.src_b = 2'b01;
    step("rst_sw/after_reset", 1'b0, 1'b0, e, 1'b0);
    check_ret("rst_sw/retired_zero", CNT_W'(0));

    // Random instruction mix
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       ins = mk_r(fl[$urandom_range(0, 9)]);
        1:       ins = mk_r(6'($urandom));
        2:       ins = mk_op(il[$urandom_range(0, 4)]);
        3:       ins = mk_op(6'b100011);
        4:       ins = mk_op(6'b101011);
        5:       ins = mk_op(6'b000100);
        6:       ins = mk_op(6'b000101);
        7:       ins = mk_op(6'b000010);
        8:       ins = $urandom;
        default: ins = mk_op(6'b111111);
      endcase
      run_instr("rand", ins, $urandom_range(0, 3), $urandom_range(0, 3), rbit());
    end

    // Counter wrap: bring model to all-ones, then one more jump
    while (ret_model != '1) run_instr("pre_wrap_j", mk_op(6'b000010), 0, 0, 1'b0);
    check_ret("at_max", '1);
    run_instr("wrap_j", mk_op(6'b000010), 0, 0, 1'b0);
    check_ret("wrapped", CNT_W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
